// File: rtl/rram_mac_if.sv
// Signal bundle between the RRAM MAC sequencer and its decoder, buffers and array.
// The master side drives launch parameters and returns buffer and ADC data; the slave side is the sequencer.
interface rram_mac_if;
  logic        start;
  logic        abort;
  logic        col_sel;
  logic [3:0]  if_start;
  logic [3:0]  if_end;
  logic [5:0]  ob_base;
  logic        busy;
  logic        done;
  logic        if_rd_en;
  logic [3:0]  if_rd_addr;
  logic [15:0] if_rd_data;
  logic [15:0] in0_wl;
  logic [15:0] in1_wl;
  logic        enable_wl;
  logic        enable_adc;
  logic        pre;
  logic [1:0]  clk_en_adc;
  logic [15:0] adc_out0;
  logic [15:0] adc_out1;
  logic [15:0] adc_out2;
  logic        ob_wr_en;
  logic [5:0]  ob_wr_addr;
  logic [31:0] ob_wr_data;

  modport master (
    output start, abort, col_sel, if_start, if_end, ob_base, if_rd_data,
           adc_out0, adc_out1, adc_out2,
    input  busy, done, if_rd_en, if_rd_addr, in0_wl, in1_wl, enable_wl, enable_adc,
           pre, clk_en_adc, ob_wr_en, ob_wr_addr, ob_wr_data
  );

  modport slave (
    input  start, abort, col_sel, if_start, if_end, ob_base, if_rd_data,
           adc_out0, adc_out1, adc_out2,
    output busy, done, if_rd_en, if_rd_addr, in0_wl, in1_wl, enable_wl, enable_adc,
           pre, clk_en_adc, ob_wr_en, ob_wr_addr, ob_wr_data
  );
endinterface

// File: rtl/rram_mac_sequencer.sv
// Runs one MAC burst on the 16x16 RRAM crossbar: fetch, WL drive, precharge, evaluate,
// ADC conversion and packed write-back of 8 column results per input vector.
module rram_mac_sequencer #(
  parameter int ARRAY_SIZE = 16,
  parameter int ADC_SETTLE = 2,
  parameter int ADC_CONV   = 4
) (
  input logic       clk,
  input logic       rst,
  rram_mac_if.slave bus
);
  localparam int CNT_MAX = (ADC_SETTLE > ADC_CONV) ? ADC_SETTLE : ADC_CONV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(ADC_SETTLE - 1);
  localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(ADC_CONV - 1);
  localparam int HALF = ARRAY_SIZE / 2;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PRECH, EVAL, CONV, WRITE, DONE} state_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        if_rd_en;
    logic        ob_wr_en;
    logic        enable_wl;
    logic        enable_adc;
    logic        pre;
    logic [1:0]  clk_en_adc;
    logic [3:0]  if_rd_addr;
    logic [5:0]  ob_wr_addr;
    logic [15:0] in0_wl;
    logic [15:0] in1_wl;
  } out_t;

  localparam out_t OUT_IDLE = '{busy: 1'b0, done: 1'b0, if_rd_en: 1'b0, ob_wr_en: 1'b0,
                                enable_wl: 1'b0, enable_adc: 1'b0, pre: 1'b1,
                                clk_en_adc: 2'b00, if_rd_addr: 4'd0, ob_wr_addr: 6'd0,
                                in0_wl: 16'hFFFF, in1_wl: 16'hFFFF};

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             col_sel_q, col_sel_next;
  logic [3:0]       ptr, ptr_next;
  logic [3:0]       if_end_q, if_end_next;
  logic [3:0]       index, index_next;
  logic [5:0]       ob_base_q, ob_base_next;
  out_t             out_q, out_d;
  logic [31:0]      packed_word;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_next   = state;
    cnt_next     = '0;
    col_sel_next = col_sel_q;
    ptr_next     = ptr;
    if_end_next  = if_end_q;
    ob_base_next = ob_base_q;
    index_next   = index;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state_next   = FETCH;
          col_sel_next = bus.col_sel;
          ptr_next     = bus.if_start;
          if_end_next  = bus.if_end;
          ob_base_next = bus.ob_base;
          index_next   = '0;
        end
        FETCH: state_next = LOAD;
        LOAD:  state_next = PRECH;
        PRECH: state_next = EVAL;
        EVAL:  if (cnt == SETTLE_LAST) state_next = CONV;  else cnt_next = cnt + 1'b1;
        CONV:  if (cnt == CONV_LAST)   state_next = WRITE; else cnt_next = cnt + 1'b1;
        WRITE: if (ptr == if_end_q) begin
          state_next = DONE;
        end else begin
          state_next = FETCH;
          ptr_next   = ptr + 4'd1;
          index_next = index + 4'd1;
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with the state they belong to.
  always_comb begin
    out_d        = OUT_IDLE;
    out_d.busy   = (state_next != IDLE);
    out_d.in0_wl = out_q.in0_wl;
    out_d.in1_wl = out_q.in1_wl;
    case (state_next)
      IDLE, DONE: begin
        out_d.done   = (state_next == DONE);
        out_d.in0_wl = '1;
        out_d.in1_wl = '1;
      end
      FETCH: begin
        out_d.if_rd_en   = 1'b1;
        out_d.if_rd_addr = ptr_next;
      end
      PRECH: out_d.pre = 1'b0;
      EVAL: begin
        out_d.enable_wl  = 1'b1;
        out_d.enable_adc = 1'b1;
        out_d.clk_en_adc = 2'b01;
      end
      CONV: begin
        out_d.enable_adc = 1'b1;
        out_d.clk_en_adc = 2'b10;
      end
      WRITE: begin
        out_d.ob_wr_en   = 1'b1;
        out_d.ob_wr_addr = ob_base_q + {2'b00, index};
      end
      default: ;
    endcase
    // A set input bit selects the read/MAC WL level (in0=0, in1=1); a clear bit grounds the row (both 1).
    if (state == LOAD && state_next == PRECH) begin
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        out_d.in0_wl[r] = ~bus.if_rd_data[r];
        out_d.in1_wl[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      col_sel_q <= 1'b0;
      ptr       <= '0;
      if_end_q  <= '0;
      index     <= '0;
      ob_base_q <= '0;
      out_q     <= OUT_IDLE;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      col_sel_q <= col_sel_next;
      ptr       <= ptr_next;
      if_end_q  <= if_end_next;
      index     <= index_next;
      ob_base_q <= ob_base_next;
      out_q     <= out_d;
    end
  end

  // Nibble k carries {adc0, adc1, adc2, valid} for column k of the selected half.
  always_comb begin
    packed_word = '0;
    for (int k = 0; k < HALF; k++) begin
      packed_word[4*k +: 4] = {bus.adc_out0[k + HALF * int'(col_sel_q)],
                               bus.adc_out1[k + HALF * int'(col_sel_q)],
                               bus.adc_out2[k + HALF * int'(col_sel_q)], 1'b1};
    end
  end

  assign bus.ob_wr_data = (state == WRITE) ? packed_word : '0;
  assign bus.busy       = out_q.busy;
  assign bus.done       = out_q.done;
  assign bus.if_rd_en   = out_q.if_rd_en;
  assign bus.if_rd_addr = out_q.if_rd_addr;
  assign bus.ob_wr_en   = out_q.ob_wr_en;
  assign bus.ob_wr_addr = out_q.ob_wr_addr;
  assign bus.enable_wl  = out_q.enable_wl;
  assign bus.enable_adc = out_q.enable_adc;
  assign bus.pre        = out_q.pre;
  assign bus.clk_en_adc = out_q.clk_en_adc;
  assign bus.in0_wl     = out_q.in0_wl;
  assign bus.in1_wl     = out_q.in1_wl;
endmodule

// File: tb/tb_rram_mac_sequencer.sv
// Self-checking bench for rram_mac_sequencer: buffer/ADC stimulus with a read and write scoreboard.
module tb_rram_mac_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rram_mac_if bus();

  rram_mac_sequencer #(.ARRAY_SIZE(16), .ADC_SETTLE(2), .ADC_CONV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic [3:0]  rd_q[$];
  wr_t         wr_q[$];
  logic [15:0] buf_mem [16];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;

  // {busy,done,if_rd_en,ob_wr_en,enable_wl,enable_adc,clk_en_adc,pre,in0_wl,in1_wl,if_rd_addr,ob_wr_addr,ob_wr_data}
  localparam logic [82:0] DEFAULTS = {8'h00, 1'b1, 32'hFFFF_FFFF, 42'h0};

  function automatic logic [82:0] out_vec();
    return {bus.busy, bus.done, bus.if_rd_en, bus.ob_wr_en, bus.enable_wl, bus.enable_adc,
            bus.clk_en_adc, bus.pre, bus.in0_wl, bus.in1_wl, bus.if_rd_addr, bus.ob_wr_addr,
            bus.ob_wr_data};
  endfunction

  function automatic logic [31:0] pack_exp(input logic cs, input logic [15:0] a0, a1, a2);
    logic [31:0] w;
    int c;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      c = cs ? k + 8 : k;
      w[4*k+3] = a0[c];
      w[4*k+2] = a1[c];
      w[4*k+1] = a2[c];
      w[4*k]   = 1'b1;
    end
    return w;
  endfunction

  // Input buffer with exactly one cycle of read latency.
  always @(posedge clk) if (bus.if_rd_en) bus.if_rd_data <= buf_mem[bus.if_rd_addr];

  // Scoreboard: every read and write strobe is matched against the next expected entry.
  always @(negedge clk) begin
    if (bus.if_rd_en) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_addr: unexpected read of %0d, none expected", bus.if_rd_addr);
      end else begin
        logic [3:0] exp_a;
        exp_a = rd_q.pop_front();
        if (bus.if_rd_addr !== exp_a) begin
          errors++;
          $display("FAIL rd_addr: got %0d expected %0d", bus.if_rd_addr, exp_a);
        end
      end
    end
    if (bus.ob_wr_en) begin
      wr_count++;
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL ob_write: unexpected write addr %0d data %h", bus.ob_wr_addr, bus.ob_wr_data);
      end else begin
        wr_t exp_w;
        exp_w = wr_q.pop_front();
        if (bus.ob_wr_addr !== exp_w.addr || bus.ob_wr_data !== exp_w.data) begin
          errors++;
          $display("FAIL ob_write: got addr %0d data %h expected addr %0d data %h",
                   bus.ob_wr_addr, bus.ob_wr_data, exp_w.addr, exp_w.data);
        end
      end
    end
    if (bus.done) done_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1, "watchdog expired");
  end

  task automatic launch(input logic cs, input logic [3:0] s, e, input logic [5:0] b);
    bus.col_sel  = cs;
    bus.if_start = s;
    bus.if_end   = e;
    bus.ob_base  = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Launches a burst and counts cycles with the first FETCH as cycle 1, up to the done pulse.
  task automatic run_burst(input logic cs, input logic [3:0] s, e, input logic [5:0] b,
                           input int restart_at, output int cycles, output logic done_seen,
                           output logic busy_at_done, output logic [15:0] wl0, wl1);
    wl0 = 'x;
    wl1 = 'x;
    launch(cs, s, e, b);
    cycles = 1;
    while (!bus.done && cycles < 200) begin
      if (cycles == restart_at) begin
        bus.start    = 1'b1;
        bus.col_sel  = ~cs;
        bus.if_start = s + 4'd4;
        bus.if_end   = s + 4'd4;
        bus.ob_base  = b + 6'd17;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cycles++;
      if (bus.enable_wl) begin
        wl0 = bus.in0_wl;
        wl1 = bus.in1_wl;
      end
    end
    bus.start    = 1'b0;
    done_seen    = bus.done;
    busy_at_done = bus.busy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vec() !== DEFAULTS) begin
      errors++;
      $display("FAIL reset_defaults: got %h expected %h", out_vec(), DEFAULTS);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_vec() !== DEFAULTS) begin
      errors++;
      $display("FAIL idle_defaults: got %h expected %h", out_vec(), DEFAULTS);
    end
  endtask

  task automatic single_common(input string name, input logic cs, input logic [5:0] b,
                               input logic [31:0] exp_data);
    int cycles;
    logic seen, busy_d;
    logic [15:0] wl0, wl1;
    rd_q.push_back(4'd3);
    wr_q.push_back('{addr: b, data: exp_data});
    run_burst(cs, 4'd3, 4'd3, b, 0, cycles, seen, busy_d, wl0, wl1);
    checks++;
    if (!seen || cycles != 11) begin
      errors++;
      $display("FAIL %s_cycles: done_seen %0b at cycle %0d expected cycle 11", name, seen, cycles);
    end
    checks++;
    if (busy_d !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_in_done: got %b expected 1", name, busy_d);
    end
    checks++;
    if (wl0 !== 16'hFFFA || wl1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL %s_wl: got %h/%h expected FFFA/FFFF", name, wl0, wl1);
    end
    checks++;
    if (out_vec() !== DEFAULTS) begin
      errors++;
      $display("FAIL %s_after_done: got %h expected %h", name, out_vec(), DEFAULTS);
    end
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes: %0d expected writes missing, 0 required", name, wr_q.size());
    end
  endtask

  task automatic test_single();
    buf_mem[3]   = 16'h0005;
    bus.adc_out0 = 16'h00FF;
    bus.adc_out1 = 16'h0000;
    bus.adc_out2 = 16'h0000;
    single_common("single", 1'b0, 6'd0, 32'h9999_9999);
  endtask

  task automatic test_col_sel();
    bus.adc_out0 = 16'h0000;
    bus.adc_out1 = 16'h0000;
    bus.adc_out2 = 16'hFF00;
    single_common("col_sel", 1'b1, 6'd0, 32'h3333_3333);
  endtask

  task automatic test_wrap();
    int cycles;
    logic seen, busy_d;
    logic [15:0] wl0, wl1;
    logic [31:0] d;
    buf_mem[14] = 16'h8001;
    buf_mem[15] = 16'h1234;
    buf_mem[0]  = 16'hFFFF;
    buf_mem[1]  = 16'h00F0;
    bus.adc_out0 = 16'hA5A5;
    bus.adc_out1 = 16'h0F0F;
    bus.adc_out2 = 16'h3C3C;
    d = pack_exp(1'b0, 16'hA5A5, 16'h0F0F, 16'h3C3C);
    rd_q.push_back(4'd14); rd_q.push_back(4'd15); rd_q.push_back(4'd0); rd_q.push_back(4'd1);
    wr_q.push_back('{addr: 6'd62, data: d});
    wr_q.push_back('{addr: 6'd63, data: d});
    wr_q.push_back('{addr: 6'd0,  data: d});
    wr_q.push_back('{addr: 6'd1,  data: d});
    run_burst(1'b0, 4'd14, 4'd1, 6'd62, 0, cycles, seen, busy_d, wl0, wl1);
    checks++;
    if (!seen || cycles != 41) begin
      errors++;
      $display("FAIL wrap_cycles: done_seen %0b at cycle %0d expected cycle 41", seen, cycles);
    end
    checks++;
    if (wl0 !== 16'hFF0F || wl1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_last_wl: got %h/%h expected FF0F/FFFF", wl0, wl1);
    end
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_count: %0d writes %0d reads missing, 0 required", wr_q.size(), rd_q.size());
    end
  endtask

  task automatic test_abort();
    int wr0, dn0;
    buf_mem[0] = 16'h0101;
    buf_mem[1] = 16'h0202;
    bus.adc_out0 = 16'h0000;
    bus.adc_out1 = 16'h00FF;
    bus.adc_out2 = 16'h0000;
    wr0 = wr_count;
    dn0 = done_count;
    rd_q.push_back(4'd0); rd_q.push_back(4'd1);
    wr_q.push_back('{addr: 6'd10, data: 32'h5555_5555});
    launch(1'b0, 4'd0, 4'd3, 6'd10);
    repeat (16) @(negedge clk);
    checks++;
    if (bus.clk_en_adc !== 2'b10 || bus.enable_adc !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_conv: clk_en_adc %b enable_adc %b expected 10/1", bus.clk_en_adc, bus.enable_adc);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (out_vec() !== DEFAULTS) begin
      errors++;
      $display("FAIL abort_defaults: got %h expected %h", out_vec(), DEFAULTS);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (wr_count - wr0 != 1 || done_count != dn0) begin
      errors++;
      $display("FAIL abort_effects: %0d writes %0d dones, expected 1 write 0 dones",
               wr_count - wr0, done_count - dn0);
    end
    bus.abort = 1'b1;
    launch(1'b0, 4'd0, 4'd0, 6'd0);
    bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.if_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL start_with_abort: busy %b rd_en %b expected 0/0", bus.busy, bus.if_rd_en);
    end
  endtask

  task automatic test_back_to_back_start();
    int cycles;
    logic seen, busy_d;
    logic [15:0] wl0, wl1;
    buf_mem[5] = 16'h0001;
    buf_mem[6] = 16'h8000;
    bus.adc_out0 = 16'h00FF;
    bus.adc_out1 = 16'h0000;
    bus.adc_out2 = 16'h0000;
    rd_q.push_back(4'd5); rd_q.push_back(4'd6);
    wr_q.push_back('{addr: 6'd20, data: 32'h9999_9999});
    wr_q.push_back('{addr: 6'd21, data: 32'h9999_9999});
    run_burst(1'b0, 4'd5, 4'd6, 6'd20, 5, cycles, seen, busy_d, wl0, wl1);
    checks++;
    if (!seen || cycles != 21) begin
      errors++;
      $display("FAIL busy_start_cycles: done_seen %0b at cycle %0d expected cycle 21", seen, cycles);
    end
    checks++;
    if (wl0 !== 16'h7FFF || wr_q.size() != 0) begin
      errors++;
      $display("FAIL busy_start_latch: wl %h, %0d writes missing; expected 7FFF, 0", wl0, wr_q.size());
    end
  endtask

  task automatic test_reset_mid_eval();
    rd_q.push_back(4'd2);
    buf_mem[2] = 16'h00FF;
    launch(1'b0, 4'd2, 4'd2, 6'd30);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.enable_wl !== 1'b1 || bus.in0_wl !== 16'hFF00) begin
      errors++;
      $display("FAIL reset_eval_reached: enable_wl %b in0_wl %h expected 1/FF00", bus.enable_wl, bus.in0_wl);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (out_vec() !== DEFAULTS) begin
      errors++;
      $display("FAIL reset_immediate: got %h expected %h", out_vec(), DEFAULTS);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    buf_mem[3]   = 16'h0005;
    bus.adc_out0 = 16'h00FF;
    bus.adc_out1 = 16'h0000;
    bus.adc_out2 = 16'h0000;
    single_common("after_reset", 1'b0, 6'd0, 32'h9999_9999);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.col_sel = 1'b0;
    bus.if_start = '0;
    bus.if_end = '0;
    bus.ob_base = '0;
    bus.adc_out0 = '0;
    bus.adc_out1 = '0;
    bus.adc_out2 = '0;
    for (int i = 0; i < 16; i++) buf_mem[i] = 16'h0000;
    test_reset();
    test_single();
    test_col_sel();
    test_wrap();
    test_abort();
    test_back_to_back_start();
    test_reset_mid_eval();
    repeat (3) @(negedge clk);
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads %0d writes outstanding, 0 required", rd_q.size(), wr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
